// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32I opcode/funct constants and issue-buffer entry type.
package alu_pkg;
   typedef enum logic [3:0] {
      CTL_AND, CTL_OR, CTL_XOR, CTL_ADD, CTL_SUB,
      CTL_SLL, CTL_SRL, CTL_SRA, CTL_SLT, CTL_SLTU
   } ctl_e;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      ctl_e        ctl;
      logic [4:0]  rd;
   } entry_t;
   // alt selects SUB/SRA in the two funct3 slots that have an alternate form
   function automatic ctl_e f3_ctl(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? CTL_SUB : CTL_ADD;
         3'b001:  return CTL_SLL;
         3'b010:  return CTL_SLT;
         3'b011:  return CTL_SLTU;
         3'b100:  return CTL_XOR;
         3'b101:  return alt ? CTL_SRA : CTL_SRL;
         3'b110:  return CTL_OR;
         default: return CTL_AND;
      endcase
   endfunction
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream/downstream handshake bundle of alu_issue.
// ALU_ISSUE_FWD_EN adds the writeback forwarding inputs.
interface alu_issue_if #(parameter int DATA_WIDTH = 32);
   logic                  in_valid, in_ready;
   logic [31:0]           in_instr, in_pc, in_rs1_data, in_rs2_data;
   logic                  flush;
   logic                  out_valid, out_ready;
   logic [DATA_WIDTH-1:0] out_a, out_b;
   logic [3:0]            out_ctl;
   logic [4:0]            out_rd;
   logic                  illegal;
`ifdef ALU_ISSUE_FWD_EN
   logic                  fwd_valid;
   logic [4:0]            fwd_rd;
   logic [31:0]           fwd_data;
`endif
   modport slave(
      input in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
`ifdef ALU_ISSUE_FWD_EN
      fwd_valid, fwd_rd, fwd_data,
`endif
      output in_ready, out_valid, out_a, out_b, out_ctl, out_rd, illegal
   );
   modport master(
      output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
`ifdef ALU_ISSUE_FWD_EN
      fwd_valid, fwd_rd, fwd_data,
`endif
      input in_ready, out_valid, out_a, out_b, out_ctl, out_rd, illegal
   );
endinterface

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I OP/OP-IMM/LUI/AUIPC decode into ALU operands and control.
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output entry_t      e,
   output logic        illegal
);
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic       is_op, is_imm, is_lui, is_auipc, shift, op_ok, imm_ok;
   assign opc      = instr[6:0];
   assign f3       = instr[14:12];
   assign f7       = instr[31:25];
   assign is_op    = opc == OPC_OP;
   assign is_imm   = opc == OPC_OPIMM;
   assign is_lui   = opc == OPC_LUI;
   assign is_auipc = opc == OPC_AUIPC;
   assign shift    = f3[1:0] == 2'b01;
   assign op_ok    = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
   // only immediate shifts reuse the funct7 field; other OP-IMM forms carry imm bits there
   assign imm_ok   = !shift || f7 == F7_BASE || (f3 == 3'b101 && f7 == F7_ALT);
   assign illegal  = !((is_op && op_ok) || (is_imm && imm_ok) || is_lui || is_auipc);
   always_comb begin
      e.a   = is_lui ? 32'd0 : is_auipc ? pc : rs1;
      e.b   = is_op ? rs2 :
              is_imm ? (shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]}) :
              {instr[31:12], 12'd0};
      e.ctl = (is_lui || is_auipc) ? CTL_ADD : f3_ctl(f3, is_op ? f7[5] : shift & f7[5]);
      e.rd  = instr[11:7];
   end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: decode RV32I ALU instructions into a DEPTH-entry FIFO feeding the ALU stage.
// ALU_ISSUE_FWD_EN enables operand forwarding from fwd_valid/fwd_rd/fwd_data at acceptance.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input logic       clk,
   input logic       rst_n,
   alu_issue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [31:0]   rs1, rs2;
   entry_t        dec, head;
   entry_t        mem [DEPTH];
   logic          dec_ill, acc, push, pop, rdy_q, ill_q;
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt, cnt_n;
`ifdef ALU_ISSUE_FWD_EN
   logic hit, fwd_op, fwd_imm;
   assign hit     = bus.fwd_valid && bus.fwd_rd != 5'd0;
   assign fwd_op  = bus.in_instr[6:0] == OPC_OP;
   assign fwd_imm = bus.in_instr[6:0] == OPC_OPIMM;
   assign rs1 = hit && (fwd_op || fwd_imm) && bus.fwd_rd == bus.in_instr[19:15] ? bus.fwd_data : bus.in_rs1_data;
   assign rs2 = hit && fwd_op && bus.fwd_rd == bus.in_instr[24:20] ? bus.fwd_data : bus.in_rs2_data;
`else
   assign rs1 = bus.in_rs1_data;
   assign rs2 = bus.in_rs2_data;
`endif
   alu_issue_decode u_dec (
      .instr(bus.in_instr), .pc(bus.in_pc), .rs1(rs1), .rs2(rs2),
      .e(dec), .illegal(dec_ill)
   );
   // flush wins over every same-cycle transfer
   assign acc   = bus.in_valid && rdy_q;
   assign push  = acc && !dec_ill && !bus.flush;
   assign pop   = bus.out_valid && bus.out_ready && !bus.flush;
   assign cnt_n = bus.flush ? '0 : cnt + CW'(push) - CW'(pop);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         wp    <= '0;
         rp    <= '0;
         rdy_q <= 1'b1;
         ill_q <= 1'b0;
      end else begin
         cnt   <= cnt_n;
         wp    <= bus.flush ? '0 : push ? wp + PW'(1) : wp;
         rp    <= bus.flush ? '0 : pop ? rp + PW'(1) : rp;
         rdy_q <= cnt_n < FULL;
         ill_q <= acc && dec_ill && !bus.flush;
      end
   always_ff @(posedge clk)
      if (push) mem[wp] <= dec;
   // payload is forced to zero whenever nothing valid is presented
   assign head          = mem[rp];
   assign bus.in_ready  = rdy_q;
   assign bus.illegal   = ill_q;
   assign bus.out_valid = cnt != '0;
   assign bus.out_a     = bus.out_valid ? DATA_WIDTH'(head.a) : '0;
   assign bus.out_b     = bus.out_valid ? DATA_WIDTH'(head.b) : '0;
   assign bus.out_ctl   = bus.out_valid ? head.ctl : 4'd0;
   assign bus.out_rd    = bus.out_valid ? head.rd : 5'd0;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: vector table, corner sequences and randomized queue-model check of alu_issue.
module tb_alu_issue;
   typedef struct {
      logic [31:0] instr, pc, rs1, rs2, a, b;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;
   typedef struct {
      logic [31:0] a, b;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tv [12];
   exp_t q [$];
   alu_issue_if #(.DATA_WIDTH(32)) bus ();
   alu_issue #(.DATA_WIDTH(32), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
      bus.in_instr    = ins;
      bus.in_pc       = pc;
      bus.in_rs1_data = r1;
      bus.in_rs2_data = r2;
   endtask
   function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      logic [6:0] op, f7;
      logic [2:0] f3;
      op = ins[6:0];
      f3 = ins[14:12];
      f7 = ins[31:25];
      e.a = r1; e.b = r2; e.ctl = 4'd0; e.rd = ins[11:7]; e.ill = 1'b0;
      case (op)
         7'h33: case ({f7, f3})
            10'h000: e.ctl = 4'd3;
            10'h100: e.ctl = 4'd4;
            10'h001: e.ctl = 4'd5;
            10'h002: e.ctl = 4'd8;
            10'h003: e.ctl = 4'd9;
            10'h004: e.ctl = 4'd2;
            10'h005: e.ctl = 4'd6;
            10'h105: e.ctl = 4'd7;
            10'h006: e.ctl = 4'd1;
            10'h007: e.ctl = 4'd0;
            default: e.ill = 1'b1;
         endcase
         7'h13: begin
            e.b = $signed(ins) >>> 20;
            case (f3)
               3'd0: e.ctl = 4'd3;
               3'd2: e.ctl = 4'd8;
               3'd3: e.ctl = 4'd9;
               3'd4: e.ctl = 4'd2;
               3'd6: e.ctl = 4'd1;
               3'd7: e.ctl = 4'd0;
               3'd1: begin e.b = {27'd0, ins[24:20]}; e.ctl = 4'd5; e.ill = f7 != 7'h00; end
               default: begin
                  e.b = {27'd0, ins[24:20]};
                  e.ctl = (f7 == 7'h20) ? 4'd7 : 4'd6;
                  e.ill = f7 != 7'h00 && f7 != 7'h20;
               end
            endcase
         end
         7'h37: begin e.a = 32'd0; e.b = ins & 32'hFFFFF000; e.ctl = 4'd3; end
         7'h17: begin e.a = pc; e.b = ins & 32'hFFFFF000; e.ctl = 4'd3; end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction
   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      int          s;
      r  = $urandom;
      s  = $urandom_range(0, 2);
      f7 = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : r[31:25];
      case ($urandom_range(0, 5))
         0, 1:    return {f7, r[24:7], 7'h33};
         2, 3:    return {f7, r[24:7], 7'h13};
         4:       return {r[31:7], r[0] ? 7'h37 : 7'h17};
         default: return r;
      endcase
   endfunction
   task automatic run_vec(input int i);
      vec_t v;
      v = tv[i];
      drive(v.instr, v.pc, v.rs1, v.rs2);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(!v.ill));
      chk($sformatf("vec%0d.illegal", i), 32'(bus.illegal), 32'(v.ill));
      if (!v.ill) begin
         chk($sformatf("vec%0d.a", i), bus.out_a, v.a);
         chk($sformatf("vec%0d.b", i), bus.out_b, v.b);
         chk($sformatf("vec%0d.ctl", i), 32'(bus.out_ctl), 32'(v.ctl));
         chk($sformatf("vec%0d.rd", i), 32'(bus.out_rd), 32'(v.rd));
      end
      step();
      chk($sformatf("vec%0d.ill_gone", i), 32'(bus.illegal), 32'd0);
      chk($sformatf("vec%0d.drained", i), 32'(bus.out_valid), 32'd0);
   endtask
   initial begin
      tv[0]  = '{32'h002081B3, 32'h0, 32'd5,        32'd7,  32'd5,        32'd7,        4'd3, 5'd3, 1'b0};
      tv[1]  = '{32'h40335293, 32'h0, 32'hF0000000, 32'd0,  32'hF0000000, 32'd3,        4'd7, 5'd5, 1'b0};
      tv[2]  = '{32'hFFFFFFFF, 32'h0, 32'd1,        32'd2,  32'd0,        32'd0,        4'd0, 5'd0, 1'b1};
      tv[3]  = '{32'h402081B3, 32'h0, 32'd10,       32'd3,  32'd10,       32'd3,        4'd4, 5'd3, 1'b0};
      tv[4]  = '{32'hFFF00093, 32'h0, 32'h1234,     32'd0,  32'h1234,     32'hFFFFFFFF, 4'd3, 5'd1, 1'b0};
      tv[5]  = '{32'h123453B7, 32'h0, 32'h55,       32'd0,  32'd0,        32'h12345000, 4'd3, 5'd7, 1'b0};
      tv[6]  = '{32'hABCDE017, 32'h100, 32'h55,     32'd0,  32'h100,      32'hABCDE000, 4'd3, 5'd0, 1'b0};
      tv[7]  = '{32'h400021B3, 32'h0, 32'd1,        32'd2,  32'd0,        32'd0,        4'd0, 5'd0, 1'b1};
      tv[8]  = '{32'h40001013, 32'h0, 32'd1,        32'd2,  32'd0,        32'd0,        4'd0, 5'd0, 1'b1};
      tv[9]  = '{32'h0020B233, 32'h0, 32'd4,        32'd9,  32'd4,        32'd9,        4'd9, 5'd4, 1'b0};
      tv[10] = '{32'h0F00F113, 32'h0, 32'hABCD,     32'd0,  32'hABCD,     32'hF0,       4'd0, 5'd2, 1'b0};
      tv[11] = '{32'h4000E093, 32'h0, 32'h77,       32'd0,  32'h77,       32'h400,      4'd1, 5'd1, 1'b0};
      rst_n = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
`ifdef ALU_ISSUE_FWD_EN
      bus.fwd_valid = 1'b0;
      bus.fwd_rd = 5'd0;
      bus.fwd_data = 32'd0;
`endif
      step();
      step();
      chk("rst.valid", 32'(bus.out_valid), 32'd0);
      chk("rst.ready", 32'(bus.in_ready), 32'd1);
      chk("rst.illegal", 32'(bus.illegal), 32'd0);
      chk("rst.a", bus.out_a, 32'd0);
      chk("rst.b", bus.out_b, 32'd0);
      chk("rst.ctl", 32'(bus.out_ctl), 32'd0);
      chk("rst.rd", 32'(bus.out_rd), 32'd0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 12; i++) run_vec(i);
      // backpressure: two accepted, third refused, drained in order
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      drive(32'h002081B3, 32'h0, 32'd1, 32'd0);
      step();
      chk("bp.ready1", 32'(bus.in_ready), 32'd1);
      drive(32'h002081B3, 32'h0, 32'd2, 32'd0);
      step();
      chk("bp.ready2", 32'(bus.in_ready), 32'd0);
      chk("bp.head2", bus.out_a, 32'd1);
      drive(32'h002081B3, 32'h0, 32'd3, 32'd0);
      step();
      chk("bp.ready3", 32'(bus.in_ready), 32'd0);
      chk("bp.stable", bus.out_a, 32'd1);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("bp.second", bus.out_a, 32'd2);
      chk("bp.ready4", 32'(bus.in_ready), 32'd1);
      step();
      chk("bp.empty", 32'(bus.out_valid), 32'd0);
      // flush with full buffer and incoming entry
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      step();
      step();
      bus.flush = 1'b1;
      step();
      chk("fl.valid", 32'(bus.out_valid), 32'd0);
      chk("fl.ready", 32'(bus.in_ready), 32'd1);
      drive(32'hFFFFFFFF, 32'h0, 32'd0, 32'd0);
      step();
      chk("fl.noillegal", 32'(bus.illegal), 32'd0);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      step();
      chk("fl.discarded", 32'(bus.out_valid), 32'd0);
      // simultaneous push and pop at count 1
      bus.in_valid = 1'b1;
      drive(32'h002081B3, 32'h0, 32'd8, 32'd0);
      step();
      drive(32'h002081B3, 32'h0, 32'd9, 32'd0);
      bus.out_ready = 1'b1;
      step();
      chk("pp.valid", 32'(bus.out_valid), 32'd1);
      chk("pp.a", bus.out_a, 32'd9);
      chk("pp.ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      step();
      chk("pp.empty", 32'(bus.out_valid), 32'd0);
      // reset asserted while an entry is held
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("mr.held", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr.valid", 32'(bus.out_valid), 32'd0);
      chk("mr.ready", 32'(bus.in_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("mr.after", 32'(bus.out_valid), 32'd0);
`ifdef ALU_ISSUE_FWD_EN
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.fwd_valid = 1'b1;
      bus.fwd_rd = 5'd1;
      bus.fwd_data = 32'h11;
      drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
      step();
      chk("fwd.a", bus.out_a, 32'h11);
      chk("fwd.b", bus.out_b, 32'd7);
      bus.fwd_rd = 5'd0;
      step();
      chk("fwd.x0", bus.out_a, 32'd5);
      bus.fwd_rd = 5'd2;
      step();
      chk("fwd.rs2", bus.out_b, 32'h11);
      bus.in_valid = 1'b0;
      bus.fwd_valid = 1'b0;
      step();
`endif
      // randomized traffic against a queue model
      q.delete();
      begin
         logic m_ill;
         m_ill = 1'b0;
         for (int c = 0; c < 600; c++) begin
            exp_t e;
            logic acc;
            logic [31:0] ins, pc, r1, r2;
            ins = gen_instr();
            pc = $urandom;
            r1 = $urandom;
            r2 = $urandom;
            drive(ins, pc, r1, r2);
            bus.in_valid = $urandom_range(0, 1);
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.flush = $urandom_range(0, 19) == 0;
            chk("rnd.valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("rnd.ready", 32'(bus.in_ready), 32'(q.size() < 2));
            chk("rnd.illegal", 32'(bus.illegal), 32'(m_ill));
            if (q.size() != 0) begin
               chk("rnd.a", bus.out_a, q[0].a);
               chk("rnd.b", bus.out_b, q[0].b);
               chk("rnd.ctl", 32'(bus.out_ctl), 32'(q[0].ctl));
               chk("rnd.rd", 32'(bus.out_rd), 32'(q[0].rd));
            end
            e = ref_dec(ins, pc, r1, r2);
            acc = bus.in_valid && q.size() < 2;
            if (bus.flush) begin
               q.delete();
               m_ill = 1'b0;
            end else begin
               m_ill = acc && e.ill;
               if (bus.out_ready && q.size() != 0) void'(q.pop_front());
               if (acc && !e.ill) q.push_back(e);
            end
            step();
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
